// File: rtl/demux4_pkg.sv
// Shared definitions for the 4-lane stream demultiplexer: lane count, select type
// and the select-to-lane decode.
package demux4_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_sel_t;

    function automatic logic [NUM_LANES-1:0] sel_onehot(input lane_sel_t sel);
        logic [NUM_LANES-1:0] onehot;
        onehot = {NUM_LANES{1'b0}};
        case (sel)
            2'b00:   onehot = 4'b0001;
            2'b01:   onehot = 4'b0010;
            2'b10:   onehot = 4'b0100;
            2'b11:   onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Single output-lane buffer: a DEPTH-entry circular FIFO whose head word is held in
// its own register, so the head keeps its last value once the lane drains.
module lane_fifo
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign full     = (r_count == CNT_MAX);
    assign empty    = (r_count == CNT_ZERO);
    assign head     = r_head;
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign w_rd_nxt = ptr_inc(r_rd_ptr);
    assign w_wr_nxt = ptr_inc(r_wr_ptr);

    // Next head: the following stored word, or din when it lands in a lane that is (or becomes) empty.
    always_comb begin
        w_head_nxt = r_head;
        if (w_pop && (r_count > CNT_ONE)) begin
            w_head_nxt = r_mem[w_rd_nxt];
        end else if (w_push && ((r_count == CNT_ZERO) || (w_pop && (r_count == CNT_ONE)))) begin
            w_head_nxt = din;
        end else begin
            w_head_nxt = r_head;
        end
    end

    // Storage, pointers, occupancy and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= CNT_ZERO;
            r_head   <= {WIDTH{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_head <= w_head_nxt;
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// Four-way stream demultiplexer: routes each accepted word to the lane named by select,
// each lane buffered independently so a full lane never blocks the others.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2   // only 2 or 4 are supported
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  lane_sel_t            select,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [WIDTH-1:0]     dout1,
    output logic [WIDTH-1:0]     dout2,
    output logic [WIDTH-1:0]     dout3,
    output logic [WIDTH-1:0]     dout4,
    output logic [NUM_LANES-1:0] dout_valid,
    input  logic [NUM_LANES-1:0] dout_ready
);

    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_empty;
    logic [NUM_LANES-1:0] w_push;
    logic [NUM_LANES-1:0] w_pop;
    logic [WIDTH-1:0]     w_head [NUM_LANES];

    // Readiness depends only on the addressed lane, so a full lane stalls only its own traffic.
    assign din_ready  = ~w_full[select];
    assign w_push     = sel_onehot(select) & {NUM_LANES{din_valid & din_ready}};
    assign w_pop      = dout_ready & ~w_empty;
    assign dout_valid = ~w_empty;

    assign dout1 = w_head[0];
    assign dout2 = w_head[1];
    assign dout3 = w_head[2];
    assign dout4 = w_head[3];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (w_push[g]),
            .pop   (w_pop[g]),
            .din   (din),
            .full  (w_full[g]),
            .empty (w_empty[g]),
            .head  (w_head[g])
        );
    end

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: vector table plus per-lane scoreboard queues,
// followed by an asynchronous mid-operation reset sequence.
module tb_demux4_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int NV    = 24;

    typedef struct {
        logic [7:0] din;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] exp_dv;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic [1:0]       select;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout1, dout2, dout3, dout4;
    logic [3:0]       dout_valid;
    logic [3:0]       dout_ready;

    int checks;
    int errors;
    vec_t vecs [NV];
    logic [7:0] q [4][$];

    demux4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .select     (select),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout1      (dout1),
        .dout2      (dout2),
        .dout3      (dout3),
        .dout4      (dout4),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dout_of(input int n);
        case (n)
            0:       return dout1;
            1:       return dout2;
            2:       return dout3;
            default: return dout4;
        endcase
    endfunction

    task automatic check_model(input string tag);
        logic [3:0] dv;
        for (int n = 0; n < 4; n++) dv[n] = (q[n].size() != 0);
        chk($sformatf("%s dout_valid", tag), dout_valid, dv);
        for (int n = 0; n < 4; n++) begin
            if (q[n].size() != 0) chk($sformatf("%s head lane%0d", tag, n + 1), dout_of(n), q[n][0]);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic m_rdy;
        @(negedge clk);
        din = v.din; select = v.sel; din_valid = v.valid; dout_ready = v.rdy;
        #1;
        m_rdy = (q[v.sel].size() < DEPTH);
        chk($sformatf("v%0d din_ready model", idx), din_ready, m_rdy);
        chk($sformatf("v%0d din_ready table", idx), din_ready, v.exp_rdy);
        for (int n = 0; n < 4; n++) begin
            if (v.rdy[n] && q[n].size() != 0) begin
                chk($sformatf("v%0d pop lane%0d", idx, n + 1), dout_of(n), q[n][0]);
                void'(q[n].pop_front());
            end
        end
        if (v.valid && m_rdy) q[v.sel].push_back(v.din);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d dout_valid table", idx), dout_valid, v.exp_dv);
        check_model($sformatf("v%0d", idx));
    endtask

    initial begin
        vec_t drain;
        checks = 0; errors = 0;
        //          din    sel    vld   dout_ready exp_rdy exp_dv
        vecs[0]  = '{8'hA5, 2'b10, 1'b1, 4'b0000, 1'b1, 4'b0100};
        vecs[1]  = '{8'h00, 2'b00, 1'b0, 4'b0100, 1'b1, 4'b0000};
        vecs[2]  = '{8'h01, 2'b00, 1'b1, 4'b0000, 1'b1, 4'b0001};
        vecs[3]  = '{8'h02, 2'b00, 1'b1, 4'b0000, 1'b1, 4'b0001};
        vecs[4]  = '{8'h03, 2'b00, 1'b1, 4'b0000, 1'b0, 4'b0001};
        vecs[5]  = '{8'h00, 2'b00, 1'b0, 4'b0001, 1'b0, 4'b0001};
        vecs[6]  = '{8'h00, 2'b00, 1'b0, 4'b0001, 1'b1, 4'b0000};
        vecs[7]  = '{8'h11, 2'b01, 1'b1, 4'b0000, 1'b1, 4'b0010};
        vecs[8]  = '{8'h22, 2'b01, 1'b1, 4'b0000, 1'b1, 4'b0010};
        vecs[9]  = '{8'h33, 2'b01, 1'b1, 4'b0010, 1'b0, 4'b0010};
        vecs[10] = '{8'h33, 2'b01, 1'b1, 4'b0000, 1'b1, 4'b0010};
        vecs[11] = '{8'h00, 2'b01, 1'b0, 4'b0010, 1'b0, 4'b0010};
        vecs[12] = '{8'h00, 2'b01, 1'b0, 4'b0010, 1'b1, 4'b0000};
        vecs[13] = '{8'h10, 2'b00, 1'b1, 4'b0000, 1'b1, 4'b0001};
        vecs[14] = '{8'h20, 2'b01, 1'b1, 4'b0000, 1'b1, 4'b0011};
        vecs[15] = '{8'h30, 2'b10, 1'b1, 4'b0000, 1'b1, 4'b0111};
        vecs[16] = '{8'h40, 2'b11, 1'b1, 4'b0000, 1'b1, 4'b1111};
        vecs[17] = '{8'h00, 2'b00, 1'b0, 4'b1111, 1'b1, 4'b0000};
        vecs[18] = '{8'h41, 2'b11, 1'b1, 4'b0000, 1'b1, 4'b1000};
        vecs[19] = '{8'h42, 2'b11, 1'b1, 4'b0000, 1'b1, 4'b1000};
        vecs[20] = '{8'h43, 2'b11, 1'b1, 4'b0000, 1'b0, 4'b1000};
        vecs[21] = '{8'h77, 2'b00, 1'b1, 4'b0000, 1'b1, 4'b1001};
        vecs[22] = '{8'h78, 2'b00, 1'b1, 4'b0001, 1'b1, 4'b1001};
        vecs[23] = '{8'h55, 2'b01, 1'b1, 4'b0000, 1'b1, 4'b1011};

        rst_n = 1'b0; din = 8'h00; select = 2'b00; din_valid = 1'b0; dout_ready = 4'b0000;
        #1;
        chk("reset dout_valid", dout_valid, 4'b0000);
        chk("reset din_ready", din_ready, 1'b1);
        chk("reset douts", {dout1, dout2, dout3, dout4}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) apply(i, vecs[i]);

        // Asynchronous reset with lanes 1, 2 and 4 occupied.
        @(negedge clk);
        din_valid = 1'b0; dout_ready = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst dout_valid", dout_valid, 4'b0000);
        chk("async rst douts", {dout1, dout2, dout3, dout4}, 32'h0);
        chk("async rst din_ready", din_ready, 1'b1);
        for (int n = 0; n < 4; n++) q[n].delete();
        din = 8'h99; select = 2'b00; din_valid = 1'b1; dout_ready = 4'b1111;
        @(posedge clk);
        #1;
        chk("in-reset edge dout_valid", dout_valid, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        din = 8'h5A; select = 2'b10; din_valid = 1'b1; dout_ready = 4'b0000;
        #1;
        chk("post-reset din_ready", din_ready, 1'b1);
        q[2].push_back(8'h5A);
        @(posedge clk);
        #1;
        chk("post-reset dout_valid", dout_valid, 4'b0100);
        chk("post-reset dout3", dout3, 8'h5A);
        check_model("post-reset");

        drain = '{8'h00, 2'b10, 1'b0, 4'b0100, 1'b1, 4'b0000};
        apply(NV, drain);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
